// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and default sizing for the hazard controller
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FREEZE  = 2'd1,
        ST_TIMEOUT = 2'd2
    } pipe_state_t;

    localparam int WD_LIMIT_DEF = 255;
    localparam int CNT_W_DEF    = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - saturating event counter with synchronous clear
// Ports: clk, clr (sync clear, wins over inc), inc (count enable), count (W-bit value, sticks at all-ones)
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / branch / memory-stall hazard control for a 5-stage pipe
// Ports: clk, rst (sync, active-high); ID_* source fields of the instruction in ID;
//        EX_* load/branch info of the instruction in EX; dmem_busy_i from data memory;
//        PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Flush_o, pipe_hold_o (Mealy controls);
//        timeout_o (sticky watchdog error); stall_cnt_o, flush_cnt_o (saturating statistics).
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int WD_LIMIT = WD_LIMIT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs_addr_i,
    input  logic [4:0]       ID_rt_addr_i,
    input  logic             ID_uses_rt_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_rt_addr_i,
    input  logic             EX_branch_taken_i,
    input  logic             dmem_busy_i,
    output logic             PC_Write_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Flush_o,
    output logic             pipe_hold_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WD_W = $clog2(WD_LIMIT + 1);

    pipe_state_t     state;
    logic [WD_W-1:0] wd_cnt;
    logic            load_use;
    logic            stall_inc;
    logic            flush_inc;

    // $zero is never a real destination, so a load into it cannot create a hazard.
    assign load_use = EX_MemRead_i && (EX_rt_addr_i != 5'd0) &&
                      ((EX_rt_addr_i == ID_rs_addr_i) ||
                       (ID_uses_rt_i && (EX_rt_addr_i == ID_rt_addr_i)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            // Stop at WD_LIMIT so a long busy stretch in TIMEOUT cannot wrap the watchdog.
            if (!dmem_busy_i) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_W'(WD_LIMIT)) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            case (state)
                ST_RUN: begin
                    if (dmem_busy_i) begin
                        state <= ST_FREEZE;
                    end
                end
                ST_FREEZE: begin
                    if (!dmem_busy_i) begin
                        state <= ST_RUN;
                    end else if (wd_cnt == WD_W'(WD_LIMIT - 1)) begin
                        state     <= ST_TIMEOUT;
                        timeout_o <= 1'b1;
                    end
                end
                ST_TIMEOUT: begin
                    state <= ST_TIMEOUT;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        PC_Write_o    = 1'b1;
        IF_ID_Write_o = 1'b1;
        IF_ID_Flush_o = 1'b0;
        ID_EX_Flush_o = 1'b0;
        pipe_hold_o   = 1'b0;
        if (rst) begin
            PC_Write_o = 1'b1;
        end else if ((state == ST_TIMEOUT) || dmem_busy_i) begin
            PC_Write_o    = 1'b0;
            IF_ID_Write_o = 1'b0;
            pipe_hold_o   = 1'b1;
        end else if (EX_branch_taken_i) begin
            // The wrong-path instruction in ID is squashed, so its load-use stall is moot.
            IF_ID_Flush_o = 1'b1;
            ID_EX_Flush_o = 1'b1;
        end else if (load_use) begin
            PC_Write_o    = 1'b0;
            IF_ID_Write_o = 1'b0;
            ID_EX_Flush_o = 1'b1;
        end
    end

    // Only hazards resolved while running count; the exit cycle of FREEZE is excluded.
    assign stall_inc = !rst && (state == ST_RUN) && !dmem_busy_i && !EX_branch_taken_i && load_use;
    assign flush_inc = !rst && (state == ST_RUN) && !dmem_busy_i && EX_branch_taken_i;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (stall_inc),
        .count (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (flush_inc),
        .count (flush_cnt_o)
    );

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter WD_LIMIT, default 255: max consecutive dmem_busy_i cycles before timeout.
REQ-002 Parameter CNT_W, default 16: width of statistics counters.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 ID_rs_addr_i  in  5  rs field of instruction in ID.
REQ-006 ID_rt_addr_i  in  5  rt field of instruction in ID.
REQ-007 ID_uses_rt_i  in  1  1 = ID instruction reads rt as a source (R-type, sw, beq).
REQ-008 EX_MemRead_i  in  1  MemRead of instruction in EX (lw).
REQ-009 EX_rt_addr_i  in  5  destination rt of instruction in EX.
REQ-010 EX_branch_taken_i  in  1  branch in EX resolved taken this cycle.
REQ-011 dmem_busy_i  in  1  data memory cannot complete the MEM access this cycle.
REQ-012 PC_Write_o  out  1  1 = PC loads next value.
REQ-013 IF_ID_Write_o  out  1  1 = IF/ID register loads.
REQ-014 IF_ID_Flush_o  out  1  1 = IF/ID loads NOP.
REQ-015 ID_EX_Flush_o  out  1  1 = ID/EX loads all-zero bubble.
REQ-016 pipe_hold_o  out  1  1 = ID/EX, EX/MEM, MEM/WB hold current contents.
REQ-017 timeout_o  out  1  sticky memory-watchdog error.
REQ-018 stall_cnt_o  out  CNT_W  load-use bubbles inserted since reset.
REQ-019 flush_cnt_o  out  CNT_W  taken-branch flushes since reset.

Function
REQ-020 Load-use hazard (LU) SHALL be EX_MemRead_i & (EX_rt_addr_i != 0) & ((EX_rt_addr_i == ID_rs_addr_i) | (ID_uses_rt_i & (EX_rt_addr_i == ID_rt_addr_i))).
REQ-021 FSM states SHALL be RUN, FREEZE, TIMEOUT; state register updates on posedge clk.
REQ-022 Transitions: RUN->FREEZE when dmem_busy_i; FREEZE->RUN when !dmem_busy_i; FREEZE->TIMEOUT when busy and watchdog == WD_LIMIT-1; TIMEOUT exits only on rst.
REQ-023 Hazard outputs SHALL be combinational (Mealy) from state and the current inputs; zero-cycle latency.
REQ-024 Priority per cycle: TIMEOUT > dmem_busy_i > EX_branch_taken_i > LU > none.
REQ-025 TIMEOUT or dmem_busy_i: PC_Write=0, IF_ID_Write=0, pipe_hold=1, both flushes=0.
REQ-026 Branch taken (not busy): PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1, pipe_hold=0; a coincident LU is discarded.
REQ-027 LU only: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0, pipe_hold=0; exactly one bubble per load, since the lw advances to MEM next cycle.
REQ-028 No event: PC_Write=1, IF_ID_Write=1, flushes=0, pipe_hold=0.
REQ-029 Watchdog counter (width ceil(log2(WD_LIMIT+1))) SHALL increment each busy cycle and clear to 0 on any cycle with !dmem_busy_i.
REQ-030 timeout_o SHALL be 1 iff state == TIMEOUT.
REQ-031 stall_cnt_o SHALL increment by 1 on each cycle where REQ-027 applies; flush_cnt_o likewise for REQ-026; both saturate at all-ones, with no wrap.
REQ-032 Counters SHALL not increment in FREEZE or TIMEOUT.

Reset
REQ-033 On rst: state=RUN, watchdog=0, stall_cnt_o=0, flush_cnt_o=0, timeout_o=0.
REQ-034 During the rst cycle, outputs SHALL read PC_Write=1, IF_ID_Write=1, flushes=0, pipe_hold=0, regardless of inputs.
REQ-035 rst asserted mid-FREEZE or in TIMEOUT SHALL return to RUN on the next edge; it overrides all other events.

Structure
REQ-036 The FSM state encoding (RUN, FREEZE, TIMEOUT) and the WD_LIMIT/CNT_W defaults SHALL live in a shared package, pipe_pkg.
REQ-037 One sub-module, sat_counter (parameterised width, synchronous clear, increment enable, saturation), SHALL be instantiated for each of stall_cnt_o and flush_cnt_o.

Verification
REQ-038 lw $2 in EX (EX_MemRead_i=1, EX_rt_addr_i=2), ID add rs=2 -> one cycle PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; stall_cnt_o 0->1.
REQ-039 EX_rt_addr_i=0 with ID rs=0 and MemRead=1 -> no stall; stall_cnt_o stays 0.
REQ-040 Branch taken and LU in the same cycle -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1; flush_cnt_o=1, stall_cnt_o=0.
REQ-041 dmem_busy_i high for 3 cycles with LU present -> pipe_hold=1, PC_Write=0 for all 3 cycles, no flush; state returns to RUN; counters unchanged.
REQ-042 WD_LIMIT=4, dmem_busy_i held for 4 cycles -> timeout_o=1 from the 5th cycle; it stays 1 after busy drops; rst clears it to 0.
REQ-043 CNT_W=2, 5 load-use events -> stall_cnt_o reads 1, 2, 3, 3, 3.
